// File: rtl/inst_loader_pkg.sv
// Shared types and sizing rules for the instruction-memory loader.
// The FSM state encoding lives here so that the loader and any future
// debug or trace logic agree on what each state value means.
package inst_loader_pkg;

    // Loader sequencing states:
    //   IDLE     - waiting for a load command
    //   SET_ADDR - one cycle that programs the first write address
    //   WRITE    - streams instruction words into memory
    //   FINISH   - one cycle that resets the program counter
    //   START    - one cycle that kicks the core
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SET_ADDR = 3'd1,
        WRITE    = 3'd2,
        FINISH   = 3'd3,
        START    = 3'd4
    } state_e;

    // Default widths of the instruction-control write interface.
    localparam int unsigned DefaultRegAddrWidth     = 32;
    localparam int unsigned DefaultInstMemDepth     = 128;
    localparam int unsigned DefaultInstMemAddrWidth = 8;

    // The command length field needs one bit more than the address so that a
    // single command can cover the whole memory (length == depth).
    function automatic int unsigned len_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/inst_loader.sv
// Writer-side front end for the instruction memory.
// Takes a load command (start address, word count, autostart), then a
// valid/ready stream of instruction words, and drives the core's
// instruction-control write port: write mode, one address write, then
// auto-incremented data writes. When the load completes it resets the
// program counter and optionally pulses the core start input.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned RegAddrWidth     = DefaultRegAddrWidth,
    parameter int unsigned InstMemDepth     = DefaultInstMemDepth,
    parameter int unsigned InstMemAddrWidth = DefaultInstMemAddrWidth,
    parameter int unsigned LenWidth         = len_width(InstMemAddrWidth)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clr_i,
    input  logic                        core_enable_i,

    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [InstMemAddrWidth-1:0] cmd_addr_i,
    input  logic [LenWidth-1:0]         cmd_len_i,
    input  logic                        cmd_autostart_i,

    input  logic                        data_valid_i,
    output logic                        data_ready_o,
    input  logic [RegAddrWidth-1:0]     data_i,

    output logic                        inst_wr_mode_o,
    output logic [InstMemAddrWidth-1:0] inst_wr_addr_o,
    output logic                        inst_wr_addr_en_o,
    output logic [RegAddrWidth-1:0]     inst_wr_data_o,
    output logic                        inst_wr_data_en_o,
    output logic                        inst_pc_reset_o,
    output logic                        start_o,

    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    // The end-of-range sum is one bit wider than the length field so that
    // address + length can never wrap before it is compared against depth.
    localparam int unsigned SumWidth = LenWidth + 1;

    state_e                      state_q;
    logic [LenWidth-1:0]         rem_q;
    logic [LenWidth-1:0]         rem_d;
    logic                        autostart_q;
    logic                        wr_mode_q;
    logic                        wr_addr_en_q;
    logic [InstMemAddrWidth-1:0] wr_addr_q;
    logic                        pc_reset_q;
    logic                        start_q;
    logic                        done_q;
    logic                        err_q;

    logic                        cmd_fire;
    logic                        data_fire;
    logic                        last_beat;
    logic                        range_err;
    logic [SumWidth-1:0]         cmd_end;

    // Handshake and range-check helpers. A command is only offered while the
    // loader is idle and the core is not running, so a running core can never
    // have its program overwritten underneath it.
    assign cmd_ready_o = (state_q == IDLE) && !core_enable_i;
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign cmd_end     = SumWidth'(cmd_addr_i) + SumWidth'(cmd_len_i);
    assign range_err   = cmd_end > SumWidth'(InstMemDepth);

    // Data beats are accepted only while streaming. Word and enable are passed
    // straight through so each accepted beat lands in memory in the same cycle;
    // the core advances its own write pointer, so no address is sent per beat.
    assign data_ready_o      = (state_q == WRITE);
    assign data_fire         = data_valid_i && data_ready_o;
    assign inst_wr_data_en_o = data_fire;
    assign inst_wr_data_o    = data_ready_o ? data_i : '0;

    // Remaining-word bookkeeping: the beat seen while one word remains is the
    // last one of this load.
    assign rem_d     = rem_q - LenWidth'(1);
    assign last_beat = (rem_q == LenWidth'(1));

    // Registered control outputs, all decoded from the FSM registers.
    assign inst_wr_mode_o    = wr_mode_q;
    assign inst_wr_addr_en_o = wr_addr_en_q;
    assign inst_wr_addr_o    = wr_addr_q;
    assign inst_pc_reset_o   = pc_reset_q;
    assign start_o           = start_q;
    assign done_o            = done_q;
    assign err_o             = err_q;
    assign busy_o            = (state_q != IDLE);

    // Load sequencer: state, word counter and every registered output are
    // updated together, so each output is set on the edge that enters the
    // state it belongs to. Write mode drops on the edge into FINISH, which
    // keeps it from ever overlapping the PC reset pulse. A clear behaves like
    // reset: the load is abandoned without a completion pulse and memory
    // already written stays as it is.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            autostart_q  <= 1'b0;
            wr_mode_q    <= 1'b0;
            wr_addr_en_q <= 1'b0;
            wr_addr_q    <= '0;
            pc_reset_q   <= 1'b0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_addr_en_q <= 1'b0;
            wr_addr_q    <= '0;
            pc_reset_q   <= 1'b0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        rem_q       <= cmd_len_i;
                        autostart_q <= cmd_autostart_i;
                        err_q       <= 1'b0;
                        if (range_err) begin
                            err_q <= 1'b1;
                        end else if (cmd_len_i == '0) begin
                            state_q    <= FINISH;
                            pc_reset_q <= 1'b1;
                            done_q     <= !cmd_autostart_i;
                        end else begin
                            state_q      <= SET_ADDR;
                            wr_mode_q    <= 1'b1;
                            wr_addr_en_q <= 1'b1;
                            wr_addr_q    <= cmd_addr_i;
                        end
                    end
                end

                SET_ADDR: begin
                    state_q <= WRITE;
                end

                WRITE: begin
                    if (data_fire) begin
                        rem_q <= rem_d;
                        if (last_beat) begin
                            state_q    <= FINISH;
                            wr_mode_q  <= 1'b0;
                            pc_reset_q <= 1'b1;
                            done_q     <= !autostart_q;
                        end
                    end
                end

                FINISH: begin
                    if (autostart_q) begin
                        state_q <= START;
                        start_q <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                START: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
